hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Owns the s0→s1 pipeline register and turns the single-bit `data_dependency` hazard into a fixed-length stall. On a hazard it holds the s0 instruction, injects NOP bubbles into s1 until every in-flight writer has retired, and drives `currently_blocked` back to the dependency detector. This prevents the still-held instruction from re-triggering during the stall. It sits between decode (s0) and execute (s1).

## Interface
Parameters:
- `MICROCODE_W`, 22, microcode word width
- `INST_DATA_W`, 25, instruction-data word width
- `STALL_CYCLES`, 3, bubbles injected per hazard (pipeline depth s1..s3); legal range 1..7

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `microcode_s0`  in  MICROCODE_W  decoded microcode of instruction in s0
- `instruction_data_s0`  in  INST_DATA_W  operand/register fields of s0 instruction
- `s0_valid`  in  1  s0 holds a real instruction
- `data_dependency`  in  1  hazard flag from the dependency detector (combinational, same cycle)
- `flush`  in  1  squash request (branch redirect)
- `microcode_s1`  out  MICROCODE_W  registered s1 microcode
- `instruction_data_s1`  out  INST_DATA_W  registered s1 instruction data
- `s1_valid`  out  1  s1 holds a real instruction
- `currently_blocked`  out  1  stall in progress; fed back to the detector
- `stall_s0`  out  1  hold fetch/decode; s0 must not change next edge
- `hazard_bubbles`  out  16  saturating count of hazard-injected bubbles

## Operation
- Reset values: `microcode_s1` = NOP (all zero), `instruction_data_s1` = 0, `s1_valid` = 0, state RUN, counter 0, `currently_blocked` = 0, `hazard_bubbles` = 0.
- Combinational output `stall_s0` = (RUN & `s0_valid` & `data_dependency` & ~`flush`) | (STALL & ~`flush`).
- Moore output `currently_blocked` = (state == STALL).

RUN state, per edge:
- `flush`: load a bubble into s1 (NOP, data 0, valid 0). Stay in RUN.
- Else if `s0_valid` & `data_dependency`: load a bubble and increment `hazard_bubbles`.
  - If `STALL_CYCLES` > 1: go to STALL and set counter = `STALL_CYCLES`−1.
  - If `STALL_CYCLES` = 1: stay in RUN.
- Otherwise: s1 ← {`microcode_s0`, `instruction_data_s0`, `s0_valid`}.

STALL state, per edge:
- `flush`: load a bubble, go to RUN, clear the counter. `hazard_bubbles` is not incremented.
- Else: load a bubble, increment `hazard_bubbles`, and decrement the counter. When the counter reads 1, go to RUN.

General rules:
- `data_dependency` is ignored while in STALL. The detector already masks it, and the unit does not rely on that masking.
- `hazard_bubbles` saturates at 0xFFFF and never wraps. Flush bubbles are not counted.
- Reset asserted mid-stall returns every output to its reset value immediately, without waiting for a clock edge.

## Timing
- Normal flow: 1-cycle latency from s0 to s1.
- Hazard first seen in cycle T: bubbles are written at edges T .. T+`STALL_CYCLES`−1.
  - `currently_blocked` is high during cycles T+1 .. T+`STALL_CYCLES`−1.
  - The held instruction enters s1 at edge T+`STALL_CYCLES`.
  - The detector re-evaluates that instruction in cycle T+`STALL_CYCLES`, with `currently_blocked` = 0.
- `stall_s0` is high from cycle T through cycle T+`STALL_CYCLES`−1 inclusive.
- `flush` and `data_dependency` asserted in the same cycle: `flush` wins, and `stall_s0` stays low.
- A back-to-back hazard on the released instruction starts a new stall in the same cycle it is re-evaluated, with no RUN gap needed.

## Structure
- Shared package `pipeline_pkg` holds:
  - `MICROCODE_W` and `INST_DATA_W`
  - `NOP_MICROCODE` constant (all zero)
  - `stall_state_t` enum {RUN, STALL}
- Counter width is $clog2(`STALL_CYCLES`), with a minimum of 1.
- One sub-module: `sat_counter`, parameterised width, with increment enable, saturating at all-ones and asynchronous reset. It implements `hazard_bubbles`.

## Test plan
- Reset asserted mid-stall (counter = 1) → all outputs return to reset values asynchronously. After release, s1 = NOP and `hazard_bubbles` = 0.
- Three valid instructions with no hazard → s1 shows each one a single edge later, `stall_s0` stays 0, and `hazard_bubbles` stays 0.
- `data_dependency` pulsed in cycle 5 with `STALL_CYCLES`=3 → bubbles at edges 5, 6, 7; `currently_blocked` = 1 in cycles 6–7; the held instruction reaches s1 at edge 8; `hazard_bubbles` = 3.
- `flush` in cycle 7 during a stall that started in cycle 5 → s1 gets a bubble, state returns to RUN, `currently_blocked` = 0 in cycle 8, and `hazard_bubbles` = 2.
- `flush` and `data_dependency` together in RUN → one bubble, state stays RUN, `stall_s0` = 0, counter unchanged.
- `hazard_bubbles` preloaded to 0xFFFE, then a 3-bubble hazard → count reads 0xFFFF and holds there.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the decode/execute boundary:
// datapath widths, the NOP encoding and the stall controller state type.
package pipeline_pkg;

    localparam int MICROCODE_W = 22;
    localparam int INST_DATA_W = 25;

    // All-zero microcode is the architectural NOP injected as a bubble
    localparam logic [MICROCODE_W-1:0] NOP_MICROCODE = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_en and sticks at all-ones
// instead of wrapping. Asynchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    // Next value of the count, held at all-ones once it gets there
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
        if (&value) begin
            return value;
        end
        return value + WIDTH'(1);
    endfunction

    // Count enabled events, saturating at the maximum value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc_en) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// s0->s1 pipeline register with hazard stall control. A data dependency
// seen in RUN holds s0 and injects STALL_CYCLES NOP bubbles into s1, during
// which currently_blocked tells the detector to stop re-flagging the held
// instruction. A flush always wins and returns the unit to RUN.
module hazard_stall_unit #(
    parameter int MICROCODE_W  = pipeline_pkg::MICROCODE_W,
    parameter int INST_DATA_W  = pipeline_pkg::INST_DATA_W,
    parameter int STALL_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MICROCODE_W-1:0] microcode_s0,
    input  logic [INST_DATA_W-1:0] instruction_data_s0,
    input  logic                   s0_valid,
    input  logic                   data_dependency,
    input  logic                   flush,
    output logic [MICROCODE_W-1:0] microcode_s1,
    output logic [INST_DATA_W-1:0] instruction_data_s1,
    output logic                   s1_valid,
    output logic                   currently_blocked,
    output logic                   stall_s0,
    output logic [15:0]            hazard_bubbles
);

    import pipeline_pkg::*;

    // Counter holds the bubbles still to inject after the first one
    localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [MICROCODE_W-1:0] NOP_MC = MICROCODE_W'(NOP_MICROCODE);

    stall_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             hazard_run;
    logic             bubble_cnt_en;

    // Hazard qualification and the combinational s0 hold request
    always_comb begin
        hazard_run    = (state == RUN) && s0_valid && data_dependency;
        stall_s0      = ~flush & (hazard_run | (state == STALL));
        // Every hazard bubble coincides with a non-flushed stall cycle;
        // flush bubbles are deliberately left out of the count
        bubble_cnt_en = stall_s0;
    end

    assign currently_blocked = (state == STALL);

    // Stall FSM and s1 register: bubble by default, pass s0 only when free to advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= RUN;
            cnt                 <= '0;
            microcode_s1        <= NOP_MC;
            instruction_data_s1 <= '0;
            s1_valid            <= 1'b0;
        end else begin
            microcode_s1        <= NOP_MC;
            instruction_data_s1 <= '0;
            s1_valid            <= 1'b0;
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= RUN;
                    end else if (hazard_run) begin
                        // A single-bubble stall needs no STALL residency
                        if (STALL_CYCLES > 1) begin
                            state <= STALL;
                            cnt   <= CNT_LOAD;
                        end
                    end else begin
                        microcode_s1        <= microcode_s0;
                        instruction_data_s1 <= instruction_data_s0;
                        s1_valid            <= s0_valid;
                    end
                end
                STALL: begin
                    // data_dependency is not consulted here: the held
                    // instruction is re-evaluated only after release
                    if (flush) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_bubble_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (bubble_cnt_en),
        .count  (hazard_bubbles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: a reference model built on
// "bubbles still to inject" predicts each s1 word, pushes it on a queue
// when the stimulus is driven, and pops/compares it after the edge.
module tb_hazard_stall_unit;

    localparam int MC_W = 22;
    localparam int ID_W = 25;
    localparam int SC   = 3;

    typedef struct packed {
        logic [MC_W-1:0] mc;
        logic [ID_W-1:0] data;
        logic            v;
    } s1_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [MC_W-1:0] microcode_s0;
    logic [ID_W-1:0] instruction_data_s0;
    logic            s0_valid;
    logic            data_dependency;
    logic            flush;
    logic [MC_W-1:0] microcode_s1;
    logic [ID_W-1:0] instruction_data_s1;
    logic            s1_valid;
    logic            currently_blocked;
    logic            stall_s0;
    logic [15:0]     hazard_bubbles;

    logic            sc_en;
    logic [2:0]      sc_count;

    int n_checks = 0;
    int n_errors = 0;

    s1_t exp_q[$];
    int  m_left = 0;
    int  m_bub  = 0;

    hazard_stall_unit #(
        .MICROCODE_W  (MC_W),
        .INST_DATA_W  (ID_W),
        .STALL_CYCLES (SC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .microcode_s0        (microcode_s0),
        .instruction_data_s0 (instruction_data_s0),
        .s0_valid            (s0_valid),
        .data_dependency     (data_dependency),
        .flush               (flush),
        .microcode_s1        (microcode_s1),
        .instruction_data_s1 (instruction_data_s1),
        .s1_valid            (s1_valid),
        .currently_blocked   (currently_blocked),
        .stall_s0            (stall_s0),
        .hazard_bubbles      (hazard_bubbles)
    );

    sat_counter #(
        .WIDTH (3)
    ) u_sat3 (
        .clk    (clk),
        .rst    (rst),
        .inc_en (sc_en),
        .count  (sc_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_s1();
        s1_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("s1_microcode", 64'(microcode_s1), 64'(e.mc));
            check_eq("s1_data", 64'(instruction_data_s1), 64'(e.data));
            check_eq("s1_valid", 64'(s1_valid), 64'(e.v));
        end
        check_eq("hazard_bubbles", 64'(hazard_bubbles), 64'(m_bub));
    endtask

    // One clock cycle: starts and ends 1 time unit after a rising edge
    task automatic drive_cycle(input logic [MC_W-1:0] mc, input logic [ID_W-1:0] data,
                               input logic v, input logic dep, input logic fl);
        s1_t e;
        logic exp_stall;
        microcode_s0        = mc;
        instruction_data_s0 = data;
        s0_valid            = v;
        data_dependency     = dep;
        flush               = fl;
        #2;
        exp_stall = !fl && ((m_left == 0 && v && dep) || m_left > 0);
        check_eq("stall_s0", 64'(stall_s0), 64'(exp_stall));
        check_eq("currently_blocked", 64'(currently_blocked), 64'(m_left > 0));
        e = '0;
        if (fl) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_bub < 65535) m_bub++;
        end else if (v && dep) begin
            m_left = SC - 1;
            if (m_bub < 65535) m_bub++;
        end else begin
            e.mc   = mc;
            e.data = data;
            e.v    = v;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        compare_s1();
    endtask

    initial begin
        rst                 = 1'b1;
        microcode_s0        = '0;
        instruction_data_s0 = '0;
        s0_valid            = 1'b0;
        data_dependency     = 1'b0;
        flush               = 1'b0;
        sc_en               = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_s1_microcode", 64'(microcode_s1), 64'd0);
        check_eq("rst_s1_data", 64'(instruction_data_s1), 64'd0);
        check_eq("rst_s1_valid", 64'(s1_valid), 64'd0);
        check_eq("rst_blocked", 64'(currently_blocked), 64'd0);
        check_eq("rst_bubbles", 64'(hazard_bubbles), 64'd0);
        check_eq("rst_stall_s0", 64'(stall_s0), 64'd0);
        rst = 1'b0;

        // Plain flow: each instruction one edge later, no stall
        drive_cycle(22'h0A0001, 25'h1000001, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h0B0002, 25'h0ABCDEF, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h3FFFFF, 25'h1FFFFFF, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h000000, 25'h0000000, 1'b0, 1'b0, 1'b0);

        // Single-cycle dependency pulse: three bubbles then release
        drive_cycle(22'h0D0D0D, 25'h0D0D0D0, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h0D0D0D, 25'h0D0D0D0, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h0D0D0D, 25'h0D0D0D0, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h0D0D0D, 25'h0D0D0D0, 1'b1, 1'b0, 1'b0);

        // Dependency left high during the stall must not extend it
        drive_cycle(22'h0E0E0E, 25'h0E0E0E0, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h0E0E0E, 25'h0E0E0E0, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h0E0E0E, 25'h0E0E0E0, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h0E0E0E, 25'h0E0E0E0, 1'b1, 1'b0, 1'b0);

        // Flush in the second stall cycle aborts the stall
        drive_cycle(22'h0F0F0F, 25'h0F0F0F0, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h0F0F0F, 25'h0F0F0F0, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h0F0F0F, 25'h0F0F0F0, 1'b1, 1'b0, 1'b1);
        drive_cycle(22'h101010, 25'h1010101, 1'b1, 1'b0, 1'b0);

        // Flush and dependency together in RUN: flush wins
        drive_cycle(22'h111111, 25'h1111111, 1'b1, 1'b1, 1'b1);
        drive_cycle(22'h121212, 25'h1212121, 1'b1, 1'b0, 1'b0);

        // Back-to-back hazard on the released instruction
        drive_cycle(22'h131313, 25'h1313131, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h131313, 25'h1313131, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h131313, 25'h1313131, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h131313, 25'h1313131, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h131313, 25'h1313131, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h131313, 25'h1313131, 1'b1, 1'b0, 1'b0);
        drive_cycle(22'h131313, 25'h1313131, 1'b1, 1'b0, 1'b0);

        // Dependency on an invalid slot is not a hazard
        drive_cycle(22'h141414, 25'h1414141, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while the counter reads 1
        drive_cycle(22'h151515, 25'h1515151, 1'b1, 1'b1, 1'b0);
        drive_cycle(22'h151515, 25'h1515151, 1'b1, 1'b0, 1'b0);
        check_eq("pre_rst_blocked", 64'(currently_blocked), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_s1_microcode", 64'(microcode_s1), 64'd0);
        check_eq("arst_s1_data", 64'(instruction_data_s1), 64'd0);
        check_eq("arst_s1_valid", 64'(s1_valid), 64'd0);
        check_eq("arst_blocked", 64'(currently_blocked), 64'd0);
        check_eq("arst_bubbles", 64'(hazard_bubbles), 64'd0);
        check_eq("arst_stall_s0", 64'(stall_s0), 64'd0);
        #1;
        rst                 = 1'b0;
        microcode_s0        = '0;
        instruction_data_s0 = '0;
        s0_valid            = 1'b0;
        data_dependency     = 1'b0;
        exp_q.delete();
        m_left = 0;
        m_bub  = 0;
        @(posedge clk);
        #1;
        check_eq("post_rst_s1_microcode", 64'(microcode_s1), 64'd0);
        check_eq("post_rst_bubbles", 64'(hazard_bubbles), 64'd0);
        drive_cycle(22'h161616, 25'h1616161, 1'b1, 1'b0, 1'b0);
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Saturation behaviour of the bubble counter, narrow instance
        sc_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("sat_count", 64'(sc_count), 64'((i < 7) ? i : 7));
        end
        sc_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("sat_hold", 64'(sc_count), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
